// File: rtl/block_edit_ctrl_if.sv
// Bundle of the block editor's front-end and datapath signals.
// master: mouse/keyboard front ends and recogniser (drive inputs, observe outputs).
// slave : block_edit_ctrl (observes inputs, drives highlight/canvas/recogniser/word RAM).
interface block_edit_ctrl_if;
    logic [9:0] mouse_x;
    logic [8:0] mouse_y;
    logic       mouse_l_click;
    logic       mouse_r_click;
    logic       key_commit;
    logic       key_cancel;
    logic       rec_done;
    logic [7:0] rec_code;
    logic [4:0] mouse_x_block;
    logic [3:0] mouse_y_block;
    logic       editing;
    logic [8:0] writing_block_pos;
    logic       canvas_clr;
    logic       canvas_we_en;
    logic       rec_start;
    logic       word_we;
    logic [8:0] word_addr;
    logic [7:0] word_data;
    logic       busy;

    modport master (
        output mouse_x, mouse_y, mouse_l_click, mouse_r_click, key_commit, key_cancel,
               rec_done, rec_code,
        input  mouse_x_block, mouse_y_block, editing, writing_block_pos, canvas_clr,
               canvas_we_en, rec_start, word_we, word_addr, word_data, busy
    );

    modport slave (
        input  mouse_x, mouse_y, mouse_l_click, mouse_r_click, key_commit, key_cancel,
               rec_done, rec_code,
        output mouse_x_block, mouse_y_block, editing, writing_block_pos, canvas_clr,
               canvas_we_en, rec_start, word_we, word_addr, word_data, busy
    );
endinterface

// File: rtl/block_edit_ctrl.sv
// Block-grid edit sequencer: maps the mouse to a block, runs per-block edit mode,
// clears the canvas, launches recognition and writes recognised codes to word RAM.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : block_edit_ctrl_if.slave (mouse/key/recogniser inputs; highlight,
//                canvas, recogniser-start and word-RAM outputs)
// All outputs are registered and decoded from the next state, so they follow the
// state one clock after the triggering input and are zero while in reset.
module block_edit_ctrl #(
    parameter int unsigned GRID_W      = 20,
    parameter int unsigned GRID_H      = 15,
    parameter int unsigned CLR_CYCLES  = 1024,
    parameter int unsigned REC_TIMEOUT = 65535
) (
    input logic              clk,
    input logic              rst_n,
    block_edit_ctrl_if.slave bus
);
    localparam int unsigned ClrW = $clog2(CLR_CYCLES + 1);
    localparam int unsigned RecW = $clog2(REC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StClearInit, StIdle, StClear, StEdit, StRecog, StWrite
    } state_e;

    state_e            state_q, state_d;
    logic [ClrW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [RecW-1:0]   rec_cnt_q, rec_cnt_d;
    logic [4:0]        xb_q, xb_d;
    logic [3:0]        yb_q, yb_d;
    logic              in_range_q, in_range_d;
    logic [4:0]        pos_x_q, pos_x_d;
    logic [3:0]        pos_y_q, pos_y_d;
    logic [7:0]        code_q, code_d;
    logic              editing_q, editing_d;
    logic              canvas_clr_q, canvas_clr_d;
    logic              we_en_q, we_en_d;
    logic              rec_start_q, rec_start_d;
    logic              word_we_q, word_we_d;
    logic              busy_q, busy_d;
    logic              click_ok;
    logic              same_block;

    // Block under the mouse, saturated to the grid edge for off-screen coordinates.
    always_comb begin
        xb_d = (bus.mouse_x[9:5] > 5'(GRID_W - 1)) ? 5'(GRID_W - 1) : bus.mouse_x[9:5];
        yb_d = (bus.mouse_y[8:5] > 4'(GRID_H - 1)) ? 4'(GRID_H - 1) : bus.mouse_y[8:5];
        in_range_d = (bus.mouse_x < 10'(GRID_W * 32)) && (bus.mouse_y < 9'(GRID_H * 32));
    end

    // Clicks act on the block currently shown by the registered highlight.
    assign click_ok   = bus.mouse_l_click && in_range_q;
    assign same_block = ({yb_q, xb_q} == {pos_y_q, pos_x_q});

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rec_cnt_d = rec_cnt_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        code_d    = code_q;
        unique case (state_q)
            StClearInit: begin
                // Counts one extra step: the first cycle after reset only loads the
                // output register, so canvas_clr is still high for CLR_CYCLES clocks.
                clr_cnt_d = clr_cnt_q + ClrW'(1);
                if (clr_cnt_q == ClrW'(CLR_CYCLES)) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end
            end
            StIdle: begin
                if (click_ok) begin
                    pos_x_d   = xb_q;
                    pos_y_d   = yb_q;
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + ClrW'(1);
                if (clr_cnt_q == ClrW'(CLR_CYCLES - 1)) begin
                    state_d   = StEdit;
                    clr_cnt_d = '0;
                end
            end
            StEdit: begin
                if (bus.key_cancel || bus.mouse_r_click) begin
                    state_d = StIdle;
                end else if (bus.key_commit) begin
                    rec_cnt_d = '0;
                    state_d   = StRecog;
                end else if (click_ok && !same_block) begin
                    pos_x_d   = xb_q;
                    pos_y_d   = yb_q;
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StRecog: begin
                rec_cnt_d = rec_cnt_q + RecW'(1);
                if (bus.key_cancel) begin
                    state_d = StIdle;
                end else if (bus.rec_done) begin
                    code_d  = bus.rec_code;
                    state_d = StWrite;
                end else if (rec_cnt_q == RecW'(REC_TIMEOUT - 1)) begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                // Advance to the following block in reading order, wrapping the grid.
                if (pos_x_q == 5'(GRID_W - 1)) begin
                    pos_x_d = '0;
                    pos_y_d = (pos_y_q == 4'(GRID_H - 1)) ? '0 : pos_y_q + 4'd1;
                end else begin
                    pos_x_d = pos_x_q + 5'd1;
                end
                clr_cnt_d = '0;
                state_d   = StClear;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        editing_d    = 1'b0;
        canvas_clr_d = 1'b0;
        we_en_d      = 1'b0;
        rec_start_d  = 1'b0;
        word_we_d    = 1'b0;
        busy_d       = 1'b0;
        unique case (state_d)
            StClearInit: begin
                canvas_clr_d = 1'b1;
                busy_d       = 1'b1;
            end
            StIdle: begin
            end
            StClear: begin
                canvas_clr_d = 1'b1;
                editing_d    = 1'b1;
                busy_d       = 1'b1;
            end
            StEdit: begin
                editing_d = 1'b1;
                we_en_d   = 1'b1;
            end
            StRecog: begin
                editing_d   = 1'b1;
                busy_d      = 1'b1;
                rec_start_d = (state_q != StRecog);
            end
            StWrite: begin
                editing_d = 1'b1;
                busy_d    = 1'b1;
                word_we_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StClearInit;
            clr_cnt_q    <= '0;
            rec_cnt_q    <= '0;
            xb_q         <= '0;
            yb_q         <= '0;
            in_range_q   <= 1'b0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            code_q       <= '0;
            editing_q    <= 1'b0;
            canvas_clr_q <= 1'b0;
            we_en_q      <= 1'b0;
            rec_start_q  <= 1'b0;
            word_we_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            rec_cnt_q    <= rec_cnt_d;
            xb_q         <= xb_d;
            yb_q         <= yb_d;
            in_range_q   <= in_range_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            code_q       <= code_d;
            editing_q    <= editing_d;
            canvas_clr_q <= canvas_clr_d;
            we_en_q      <= we_en_d;
            rec_start_q  <= rec_start_d;
            word_we_q    <= word_we_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mouse_x_block     = xb_q;
    assign bus.mouse_y_block     = yb_q;
    assign bus.editing           = editing_q;
    assign bus.writing_block_pos = {pos_y_q, pos_x_q};
    assign bus.canvas_clr        = canvas_clr_q;
    assign bus.canvas_we_en      = we_en_q;
    assign bus.rec_start         = rec_start_q;
    assign bus.word_we           = word_we_q;
    assign bus.word_addr         = {pos_y_q, pos_x_q};
    assign bus.word_data         = code_q;
    assign bus.busy              = busy_q;
endmodule
